// File: rtl/instr_queue_ir.sv
// instr_queue_ir: prefetch FIFO of DEPTH instruction words feeding one IR register,
// with the IR fields decoded as registered slices. All state updates on the falling edge of CLK.
// Optional feature: define IRQ_BYPASS_EN to load Din straight into the IR when the queue is
// empty and IRWrite coincides with an accepted push.
module instr_queue_ir #(
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [IW-1:0]              Din,
    input  logic                       DinValid,
    output logic                       DinReady,
    input  logic                       IRWrite,
    input  logic                       Flush,
    output logic                       IRValid,
    output logic [$clog2(DEPTH):0]     Occupancy,
    output logic [3:0]                 Opcode,
    output logic [3:0]                 funct,
    output logic [IW-5:0]              Imm,
    output logic [2:0]                 RegSelect,
    output logic [2:0]                 RegSelect2,
    output logic [3:0]                 Delta,
    output logic                       LocationSelect
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          irvalid_q, irvalid_d;

    logic push;
    logic pop;
    logic bypass;
    logic qwrite;

    // Ready depends on stored occupancy only, never on DinValid.
    assign DinReady = (occ_q != OW'(DEPTH));
    assign push     = DinValid & DinReady;
    assign pop      = IRWrite & (occ_q != '0);

`ifdef IRQ_BYPASS_EN
    assign bypass = IRWrite & push & (occ_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word goes to the IR and never occupies a queue slot.
    assign qwrite = push & ~bypass;

    // Next-state for pointers, occupancy and IR; Flush overrides push/pop but keeps IR fields.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        ir_d      = ir_q;
        irvalid_d = irvalid_q;

        if (qwrite) tail_d = tail_q + PW'(1);
        if (pop)    head_d = head_q + PW'(1);

        case ({qwrite, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (IRWrite) begin
            if (bypass) begin
                ir_d      = Din;
                irvalid_d = 1'b1;
            end else if (pop) begin
                ir_d      = mem_q[head_q];
                irvalid_d = 1'b1;
            end else begin
                irvalid_d = 1'b0;  // bubble: fields hold, IR marked dead
            end
        end

        if (Flush) begin
            head_d    = '0;
            tail_d    = '0;
            occ_d     = '0;
            ir_d      = ir_q;
            irvalid_d = 1'b0;
        end
    end

    // Queue storage; written only on an accepted, non-bypassed push.
    always_ff @(negedge CLK) begin
        if (!Reset && !Flush && qwrite) begin
            mem_q[tail_q] <= Din;
        end
    end

    // Control and IR state with synchronous reset.
    always_ff @(negedge CLK) begin
        if (Reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            ir_q      <= '0;
            irvalid_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            ir_q      <= ir_d;
            irvalid_q <= irvalid_d;
        end
    end

    assign IRValid        = irvalid_q;
    assign Occupancy      = occ_q;
    assign Opcode         = ir_q[IW-1:IW-4];
    assign funct          = ir_q[IW-5:IW-8];
    assign Imm            = ir_q[IW-5:0];
    assign RegSelect      = ir_q[7:5];
    assign RegSelect2     = ir_q[3:1];
    assign Delta          = ir_q[4:1];
    assign LocationSelect = ir_q[0];

endmodule

// File: doc/instr_queue_ir.md
INSTR_QUEUE_IR -- requirements
Module: instr_queue_ir

Interface
REQ-001 The block SHALL provide parameter IW, default 16, meaning instruction word width in bits; legal values are 16 or greater.
REQ-002 The block SHALL provide parameter DEPTH, default 2, meaning number of prefetch queue entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL provide ports as follows:
- CLK  in  1  clock; all state updates occur on the falling edge.
- Reset  in  1  synchronous, active-high reset.
- Din  in  IW  fetched instruction word.
- DinValid  in  1  Din is valid this cycle.
- DinReady  out  1  queue can accept Din.
- IRWrite  in  1  load the IR from the queue head.
- Flush  in  1  discard the queued words and the IR contents.
- IRValid  out  1  IR holds a live instruction.
- Occupancy  out  clog2(DEPTH)+1  number of queued words.
- Opcode  out  4  IR[IW-1:IW-4].
- funct  out  4  IR[IW-5:IW-8].
- Imm  out  IW-4  IR[IW-5:0].
- RegSelect  out  3  IR[7:5].
- RegSelect2  out  3  IR[3:1].
- Delta  out  4  IR[4:1].
- LocationSelect  out  1  IR[0].

Function
REQ-004 The block SHALL contain a FIFO of DEPTH words of width IW, followed by one IR register; all decode outputs SHALL be registered slices of the IR.
REQ-005 DinReady SHALL equal (Occupancy != DEPTH) and SHALL be combinational from state only, with no dependence on DinValid.
REQ-006 A push SHALL occur on a falling edge where DinValid=1 and DinReady=1; Din SHALL be written at the tail, and the tail pointer SHALL wrap modulo DEPTH.
REQ-007 A pop SHALL occur on a falling edge where IRWrite=1 and Occupancy>0; the head word SHALL load into the IR, IRValid SHALL be set to 1, and the head pointer SHALL wrap modulo DEPTH.
REQ-008 IRWrite=1 with Occupancy=0 SHALL leave the decode fields unchanged and clear IRValid to 0 (bubble), except as stated in REQ-015.
REQ-009 IRWrite=0 SHALL hold the IR and IRValid unchanged.
REQ-010 A simultaneous push and pop SHALL leave Occupancy unchanged. Because a push requires DinReady=1, a push into a full queue cannot occur, even when a pop happens in the same cycle.
REQ-011 Default (non-bypass) latency SHALL be two falling edges from the push of a word to that word appearing in the IR.
REQ-012 Flush=1 SHALL set Occupancy and both pointers to 0 and clear IRValid. Flush SHALL take priority over any push or pop on the same edge. The decode fields SHALL hold their values.
REQ-013 Words SHALL leave the queue in strict push order, with no loss or duplication.

Reset
REQ-014 Reset=1 at a falling edge SHALL clear:
- Occupancy, the head pointer and the tail pointer;
- IRValid;
- Opcode, funct, Imm, RegSelect, RegSelect2, Delta and LocationSelect, all to 0.
Reset SHALL override Flush, push and pop. Reset asserted mid-stream SHALL discard all queued words. DinReady SHALL be 1 on the first cycle after Reset is released.

Configuration
REQ-015 When the macro IRQ_BYPASS_EN is defined, IRWrite=1 with Occupancy=0 and an accepted push on the same edge SHALL load Din directly into the IR and set IRValid=1; Occupancy SHALL stay 0. Without the macro, that case SHALL push Din into the queue and follow REQ-008.

Verification
REQ-016 Reset, then push 0x1234 and then 0x5ABE, then assert IRWrite -> Opcode=0x1, funct=0x2, Imm=0x234, IRValid=1, Occupancy=1.
REQ-017 With DEPTH=2, push 0xA001, 0xB002 and 0xC003 back-to-back with no IRWrite -> DinReady=0 after the second push, 0xC003 is held off, Occupancy=2.
REQ-018 With DEPTH=2, push and pop concurrently for 8 cycles using words 0x0001..0x0008 -> the IR sequence is 0x0001..0x0008 in order, and the pointers wrap with Occupancy constant.
REQ-019 Occupancy=2 and IRValid=1, then Flush together with DinValid=1 (Din=0xFFFF) -> Occupancy=0, IRValid=0, and 0xFFFF is not queued.
REQ-020 Empty queue, IRWrite=1, DinValid=1, Din=0x30EB -> with IRQ_BYPASS_EN: RegSelect=7, RegSelect2=5, Delta=5, LocationSelect=1, IRValid=1 on the same edge; without it: IRValid=0 and Occupancy=1.
REQ-021 Occupancy=1, then Reset asserted together with IRWrite=1 -> all outputs 0, DinReady=1.
